// File: rtl/jtframe_dwnld_pkg.sv
// jtframe_dwnld_pkg: shared states, byte-mask constants and helpers for the download sequencer
package jtframe_dwnld_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ROM, ST_NV, ST_CHEAT, ST_UP, ST_FLUSH} state_t;
  localparam logic [1:0] MASK_LO  = 2'b10;
  localparam logic [1:0] MASK_HI  = 2'b01;
  localparam logic [1:0] MASK_ALL = 2'b00;
  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return a < b ? a : b;
  endfunction
endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// jtframe_dwnld_fifo: synchronous FIFO, simultaneous push/pop allowed even when full
module jtframe_dwnld_fifo #(
  parameter int W       = 8,
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);
  logic [W-1:0] mem [1<<FIFO_AW];
  logic [FIFO_AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count[FIFO_AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end
endmodule

// File: rtl/jtframe_dwnld_sched.sv
// jtframe_dwnld_sched: routes data_io bytes to SDRAM words, NVRAM and cheat RAM; serves NVRAM uploads
import jtframe_dwnld_pkg::*;
module jtframe_dwnld_sched #(
  parameter int         AW        = 22,
  parameter int         FIFO_AW   = 2,
  parameter logic [7:0] IDX_CHEAT = 8'h10,
  parameter logic [7:0] IDX_NVRAM = 8'hFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [25:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  output logic [7:0]    ioctl_din,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic [15:0]   nv_addr,
  output logic [7:0]    nv_dout,
  output logic          nv_we,
  input  logic [7:0]    nv_din,
  output logic [9:0]    cheat_addr,
  output logic [7:0]    cheat_dout,
  output logic          cheat_we,
  output logic          busy,
  output logic          done,
  output logic          ovf
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int RW    = FIFO_AW + 2;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } word_t;
  state_t st;
  word_t n0, n1, skid, head;
  logic [7:0] pend;
  logic [AW-1:0] pend_addr, waddr;
  logic pend_v, skid_v, rom_wr, match, rom_start, pop, fifo_push, fifo_empty, fifo_full, unused;
  logic [1:0] n_cnt, acc, lim;
  logic [FIFO_AW:0] cnt;
  logic [RW-1:0] room;
  assign waddr     = ioctl_addr[AW:1];
  assign rom_wr    = st == ST_ROM & ioctl_wr;
  assign match     = pend_v & pend_addr == waddr;
  assign rom_start = st == ST_IDLE & ~ioctl_upload & ioctl_download &
                     ioctl_index != IDX_NVRAM & ioctl_index != IDX_CHEAT;
  assign busy      = st != ST_IDLE;
  assign ioctl_din = nv_din;
  assign prog_we   = ~fifo_empty;
  assign pop       = prog_we & prog_rdy;
  assign {prog_addr, prog_data, prog_mask} = head;
  assign unused    = ^{ioctl_addr[25:AW+1], fifo_full};
  // Up to two new words per byte: n0 goes first, n1 only on an unmatched odd byte after a pending one
  always_comb begin
    n0    = {pend_addr, 8'h00, pend, MASK_LO};
    n1    = {waddr, ioctl_dout, 8'h00, MASK_HI};
    n_cnt = 2'd0;
    if (st == ST_FLUSH) n_cnt = {1'b0, pend_v};
    else if (rom_wr) begin
      if (!ioctl_addr[0]) n_cnt = {1'b0, pend_v};
      else if (match) begin
        n0    = {waddr, ioctl_dout, pend, MASK_ALL};
        n_cnt = 2'd1;
      end else if (pend_v) n_cnt = 2'd2;
      else begin
        n0    = n1;
        n_cnt = 2'd1;
      end
    end
  end
  // The skid word counts against capacity, so it can always drain on the next cycle
  assign room      = RW'(DEPTH) - RW'(cnt) - RW'(skid_v) + RW'(pop);
  assign lim       = min2(skid_v ? 2'd1 : 2'd2, room >= RW'(2) ? 2'd2 : room[1:0]);
  assign acc       = min2(n_cnt, lim);
  assign fifo_push = skid_v | acc != 2'd0;
  jtframe_dwnld_fifo #(.W($bits(word_t)), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst | rom_start),
    .push  (fifo_push),
    .pop   (pop),
    .din   (skid_v ? skid : n0),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      st         <= ST_IDLE;
      pend       <= '0;
      pend_addr  <= '0;
      pend_v     <= 1'b0;
      skid       <= '0;
      skid_v     <= 1'b0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      nv_addr    <= '0;
      nv_dout    <= '0;
      nv_we      <= 1'b0;
      cheat_addr <= '0;
      cheat_dout <= '0;
      cheat_we   <= 1'b0;
    end else begin
      done     <= 1'b0;
      nv_we    <= 1'b0;
      cheat_we <= 1'b0;
      skid     <= skid_v ? n0 : n1;
      skid_v   <= skid_v ? acc == 2'd1 : acc == 2'd2;
      if (n_cnt > acc) ovf <= 1'b1;
      case (st)
        ST_IDLE:
          if (ioctl_upload) st <= ST_UP;
          else if (ioctl_download) begin
            st <= ioctl_index == IDX_NVRAM ? ST_NV : ioctl_index == IDX_CHEAT ? ST_CHEAT : ST_ROM;
            if (rom_start) begin
              ovf    <= 1'b0;
              pend_v <= 1'b0;
              skid_v <= 1'b0;
            end
          end
        ST_ROM: begin
          if (rom_wr) begin
            pend_v <= ~ioctl_addr[0];
            if (!ioctl_addr[0]) begin
              pend      <= ioctl_dout;
              pend_addr <= waddr;
            end
          end
          if (!ioctl_download) st <= ST_FLUSH;
        end
        ST_FLUSH: begin
          pend_v <= 1'b0;
          if (!pend_v && !skid_v && fifo_empty) begin
            done <= 1'b1;
            st   <= ST_IDLE;
          end
        end
        ST_NV: begin
          if (ioctl_wr) begin
            nv_we   <= 1'b1;
            nv_addr <= ioctl_addr[15:0];
            nv_dout <= ioctl_dout;
          end
          if (!ioctl_download) st <= ST_IDLE;
        end
        ST_CHEAT: begin
          if (ioctl_wr) begin
            cheat_we   <= 1'b1;
            cheat_addr <= ioctl_addr[9:0];
            cheat_dout <= ioctl_dout;
          end
          if (!ioctl_download) st <= ST_IDLE;
        end
        ST_UP: begin
          nv_addr <= ioctl_addr[15:0];
          if (!ioctl_upload) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
endmodule
